serial_magnitude_decoder: RTL and testbench

SERIAL_MAGNITUDE_DECODER -- requirements
Module: serial_magnitude_decoder

---
 rtl/serial_magnitude_decoder_pkg.sv | 15 +
 rtl/serial_negate_cell.sv | 23 ++
 rtl/serial_magnitude_decoder.sv | 81 ++++++++
 tb/tb_serial_magnitude_decoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_magnitude_decoder_pkg.sv
// Shared definitions for the bit-serial two's-complement magnitude decoder.
package serial_magnitude_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } smdState_t;

   // Width of a counter that must reach n-1.
   function automatic int cntWidth(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_negate_cell.sv
// One-bit serial conditional negate: pass bits up to and including the first 1, then
// invert the rest when sign is set.
module serial_negate_cell (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic sign,
   input  logic inBit,
   output logic outBit
);

   logic seenOne;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)      seenOne <= 1'b0;
      else if (clear)  seenOne <= 1'b0;
      else if (enable) seenOne <= seenOne | inBit;
   end

   assign outBit = inBit ^ (sign & seenOne);

endmodule

// File: rtl/serial_magnitude_decoder.sv
// Accepts a two's-complement word, serially computes |x| LSB first over nrOfBits cycles,
// then holds magnitude/sign/isMin until the consumer takes them.
module serial_magnitude_decoder
   import serial_magnitude_decoder_pkg::*;
#(
   parameter int nrOfBits = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [nrOfBits-1:0] dataX,
   input  logic                inValid,
   output logic                inReady,
   output logic [nrOfBits-1:0] magnitude,
   output logic                sign,
   output logic                isMin,
   output logic                outValid,
   input  logic                outReady
);

   localparam int CW = cntWidth(nrOfBits);
   localparam logic [nrOfBits-1:0] MIN_VAL = {1'b1, {(nrOfBits-1){1'b0}}};

   smdState_t           state, nextState;
   logic [CW-1:0]       bitCount;
   logic [nrOfBits-1:0] shreg;
   logic                accept, shiftEn, lastBit, outBit;

   assign accept  = (state == IDLE) && inValid;
   assign shiftEn = (state == SHIFT);
   assign lastBit = (bitCount == CW'(nrOfBits - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (inValid)  nextState = SHIFT;
         SHIFT:   if (lastBit)  nextState = DONE;
         DONE:    if (outReady) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // magnitude doubles as the result shift register; it is only meaningful in DONE
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bitCount  <= '0;
         shreg     <= '0;
         magnitude <= '0;
         sign      <= 1'b0;
         isMin     <= 1'b0;
      end else if (accept) begin
         bitCount <= '0;
         shreg    <= dataX;
         sign     <= dataX[nrOfBits-1];
         isMin    <= (dataX == MIN_VAL);
      end else if (shiftEn) begin
         bitCount  <= bitCount + 1'b1;
         shreg     <= shreg >> 1;
         magnitude <= {outBit, magnitude[nrOfBits-1:1]};
      end
   end

   serial_negate_cell uNeg (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept),
      .enable (shiftEn),
      .sign   (sign),
      .inBit  (shreg[0]),
      .outBit (outBit)
   );

   // reset gates inReady so nothing is offered while the block is held in reset
   assign inReady  = (state == IDLE) && reset;
   assign outValid = (state == DONE);

endmodule

// File: tb/tb_serial_magnitude_decoder.sv
// Directed and random-stream bench for serial_magnitude_decoder (nrOfBits = 8).
module tb_serial_magnitude_decoder;

   localparam int N = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] dataX = '0;
   logic         inValid = 1'b0;
   logic         inReady;
   logic [N-1:0] magnitude;
   logic         sign, isMin, outValid;
   logic         outReady = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   serial_magnitude_decoder #(.nrOfBits(N)) dut (
      .clock     (clock),
      .reset     (reset),
      .dataX     (dataX),
      .inValid   (inValid),
      .inReady   (inReady),
      .magnitude (magnitude),
      .sign      (sign),
      .isMin     (isMin),
      .outValid  (outValid),
      .outReady  (outReady)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for outValid after an acceptance edge; returns number of edges taken.
   task automatic waitResult(output int lat);
      lat = 0;
      while (!outValid && lat < 20) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
      end
   endtask

   task automatic runWord(input logic [7:0] x, input logic [7:0] eMag, input logic eSign,
                          input logic eMin);
      int lat;
      @(negedge clock);
      chk("idleReady", inReady, 1);
      dataX   = x;
      inValid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      inValid = 1'b0;
      waitResult(lat);
      chk($sformatf("lat_%02h", x), lat, 8);
      chk($sformatf("mag_%02h", x), magnitude, eMag);
      chk($sformatf("sign_%02h", x), sign, eSign);
      chk($sformatf("isMin_%02h", x), isMin, eMin);
      outReady = 1'b1;
      @(posedge clock);
      @(negedge clock);
      outReady = 1'b0;
      chk("dropValid", outValid, 0);
      chk("riseReady", inReady, 1);
   endtask

   initial begin
      int lat, seen, sent, got, cyc;
      logic [7:0] q[$];
      logic [7:0] hold, x;

      // reset state
      #3;
      chk("rstMag", magnitude, 0);
      chk("rstValid", outValid, 0);
      chk("rstReady", inReady, 0);
      @(negedge clock);
      reset = 1'b1;
      #1 chk("readyAfterRst", inReady, 1);

      // directed edge values
      runWord(8'hFB, 8'h05, 1'b1, 1'b0);
      runWord(8'h80, 8'h80, 1'b1, 1'b1);
      runWord(8'hFF, 8'h01, 1'b1, 1'b0);
      runWord(8'h00, 8'h00, 1'b0, 1'b0);
      runWord(8'h7F, 8'h7F, 1'b0, 1'b0);
      runWord(8'h01, 8'h01, 1'b0, 1'b0);
      runWord(8'h85, 8'h7B, 1'b1, 1'b0);

      // backpressure: hold DONE while a new word is offered
      @(negedge clock);
      dataX = 8'h85; inValid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      inValid = 1'b0;
      waitResult(lat);
      chk("bpLat", lat, 8);
      dataX = 8'h11; inValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         @(negedge clock);
         chk("bpMag", magnitude, 8'h7B);
         chk("bpSign", sign, 1);
         chk("bpValid", outValid, 1);
         chk("bpReady", inReady, 0);
      end
      outReady = 1'b1;
      @(posedge clock);
      @(negedge clock);
      outReady = 1'b0;
      chk("bpRelValid", outValid, 0);
      chk("bpRelReady", inReady, 1);
      @(posedge clock);
      @(negedge clock);
      inValid = 1'b0;
      chk("bpAccepted", inReady, 0);
      waitResult(lat);
      chk("bp11Lat", lat, 8);
      chk("bp11Mag", magnitude, 8'h11);
      chk("bp11Sign", sign, 0);
      outReady = 1'b1;
      @(posedge clock);
      @(negedge clock);
      outReady = 1'b0;

      // reset three cycles into SHIFT
      dataX = 8'hFB; inValid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      inValid = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      chk("midRstMag", magnitude, 0);
      chk("midRstSign", sign, 0);
      chk("midRstIsMin", isMin, 0);
      chk("midRstValid", outValid, 0);
      chk("midRstReady", inReady, 0);
      @(negedge clock);
      reset = 1'b1;
      #1 chk("midRstReadyAfter", inReady, 1);
      seen = 0;
      repeat (12) begin
         @(negedge clock);
         if (outValid) seen++;
      end
      chk("midRstNoValid", seen, 0);

      // random stream with random handshakes
      sent = 0; got = 0; cyc = 0;
      while (got < 1000 && cyc < 60000) begin
         @(negedge clock);
         cyc++;
         outReady = ($urandom_range(0, 1) == 1);
         inValid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
         dataX    = N'($urandom);
         #1;
         if (inValid && inReady) begin
            q.push_back(dataX);
            sent++;
         end
         if (outValid && outReady) begin
            if (q.size() == 0) begin
               chk("streamUnderflow", 1, 0);
            end else begin
               x    = q.pop_front();
               hold = x[7] ? 8'(-x) : x;
               chk("streamMag", magnitude, hold);
               chk("streamSign", sign, x[7]);
               chk("streamIsMin", isMin, (x == 8'h80));
            end
            got++;
         end
      end
      inValid = 1'b0; outReady = 1'b0;
      chk("streamCount", got, 1000);
      chk("streamLeft", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
